// File: rtl/riscv_multicycle_controller_pkg.sv
// rtl/riscv_multicycle_controller_pkg.sv - shared encodings for the multicycle RV32I controller
package riscv_multicycle_controller_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXER,
    EXEI, ALUWB, BRANCH, JAL, JALR, LINK, LUI
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_A     = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;
  localparam logic [1:0] SRCB_ZERO = 2'd3;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;
  localparam logic [1:0] RES_IMMEXT    = 2'd3;

  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_I, OP_LW, OP_JALR: imm_decode = IMM_I;
      OP_SW:                imm_decode = IMM_S;
      OP_BR:                imm_decode = IMM_B;
      OP_JAL:               imm_decode = IMM_J;
      OP_LUI:               imm_decode = IMM_U;
      default:              imm_decode = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_multicycle_controller_if.sv
// rtl/riscv_multicycle_controller_if.sv - controller <-> datapath control bundle
interface riscv_multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] func3;
  logic       func7;
  logic       zero;
  logic       neg;
  logic       PCWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       IRWrite;
  logic [1:0] resultSrc;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] immSrc;
  logic       regWrite;

  modport master (
    input  op, func3, func7, zero, neg,
    output PCWrite, adrSrc, memWrite, IRWrite, resultSrc, ALUControl,
           ALUSrcA, ALUSrcB, immSrc, regWrite
  );

  modport slave (
    output op, func3, func7, zero, neg,
    input  PCWrite, adrSrc, memWrite, IRWrite, resultSrc, ALUControl,
           ALUSrcA, ALUSrcB, immSrc, regWrite
  );
endinterface

// File: rtl/riscv_alu_decoder.sv
// rtl/riscv_alu_decoder.sv - func3/func7 to ALUControl for register and immediate ALU ops
module riscv_alu_decoder
  import riscv_multicycle_controller_pkg::*;
(
  input  logic       isRtype,
  input  logic [2:0] func3,
  input  logic       func7,
  output logic [2:0] ALUControl
);

  // Shift encodings (001/101) fall through to add; the destination is still written.
  always_comb begin
    ALUControl = ALU_ADD;
    case (func3)
      3'b000:  ALUControl = (isRtype && func7) ? ALU_SUB : ALU_ADD;
      3'b111:  ALUControl = ALU_AND;
      3'b110:  ALUControl = ALU_OR;
      3'b100:  ALUControl = ALU_XOR;
      3'b010:  ALUControl = ALU_SLT;
      3'b011:  ALUControl = ALU_SLTU;
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// rtl/riscv_multicycle_controller.sv - Moore control FSM sequencing the multicycle RV32I datapath
module riscv_multicycle_controller
  import riscv_multicycle_controller_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  riscv_multicycle_controller_if.master ctrl
);

  state_t     state, state_nxt;
  logic [2:0] alu_dec;
  logic       br_taken;

  riscv_alu_decoder u_alu_decoder (
    .isRtype    (ctrl.op == OP_R),
    .func3      (ctrl.func3),
    .func7      (ctrl.func7),
    .ALUControl (alu_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Branch compare uses the sign bit of A-B directly; signed overflow is not corrected.
  always_comb begin
    br_taken = 1'b0;
    case (ctrl.func3)
      3'b000:  br_taken = ctrl.zero;
      3'b001:  br_taken = ~ctrl.zero;
      3'b100:  br_taken = ctrl.neg;
      3'b101:  br_taken = ~ctrl.neg;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (ctrl.op)
          OP_R:         state_nxt = EXER;
          OP_I:         state_nxt = EXEI;
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_BR:        state_nxt = BRANCH;
          OP_JAL:       state_nxt = JAL;
          OP_JALR:      state_nxt = JALR;
          OP_LUI:       state_nxt = LUI;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR:  state_nxt = (ctrl.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: state_nxt = MEMWB;
      EXER:    state_nxt = ALUWB;
      EXEI:    state_nxt = ALUWB;
      JAL:     state_nxt = LINK;
      JALR:    state_nxt = LINK;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    ctrl.PCWrite    = 1'b0;
    ctrl.adrSrc     = 1'b0;
    ctrl.memWrite   = 1'b0;
    ctrl.IRWrite    = 1'b0;
    ctrl.resultSrc  = RES_ALUOUT;
    ctrl.ALUControl = ALU_ADD;
    ctrl.ALUSrcA    = SRCA_PC;
    ctrl.ALUSrcB    = SRCB_B;
    ctrl.immSrc     = imm_decode(ctrl.op);
    ctrl.regWrite   = 1'b0;
    case (state)
      FETCH: begin
        ctrl.IRWrite   = 1'b1;
        ctrl.PCWrite   = 1'b1;
        ctrl.ALUSrcB   = SRCB_FOUR;
        ctrl.resultSrc = RES_ALURESULT;
        ctrl.immSrc    = IMM_I;
      end
      DECODE: begin
        ctrl.ALUSrcA = SRCA_OLDPC;
        ctrl.ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ctrl.ALUSrcA = SRCA_A;
        ctrl.ALUSrcB = SRCB_IMM;
      end
      MEMREAD:  ctrl.adrSrc = 1'b1;
      MEMWB: begin
        ctrl.resultSrc = RES_DATA;
        ctrl.regWrite  = 1'b1;
      end
      MEMWRITE: begin
        ctrl.adrSrc   = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      EXER: begin
        ctrl.ALUSrcA    = SRCA_A;
        ctrl.ALUControl = alu_dec;
      end
      EXEI: begin
        ctrl.ALUSrcA    = SRCA_A;
        ctrl.ALUSrcB    = SRCB_IMM;
        ctrl.ALUControl = alu_dec;
      end
      ALUWB:    ctrl.regWrite = 1'b1;
      BRANCH: begin
        ctrl.ALUSrcA    = SRCA_A;
        ctrl.ALUControl = ALU_SUB;
        ctrl.PCWrite    = br_taken;
      end
      JAL:      ctrl.PCWrite = 1'b1;
      JALR: begin
        ctrl.ALUSrcA   = SRCA_A;
        ctrl.ALUSrcB   = SRCB_IMM;
        ctrl.resultSrc = RES_ALURESULT;
        ctrl.PCWrite   = 1'b1;
      end
      LINK: begin
        ctrl.ALUSrcA   = SRCA_OLDPC;
        ctrl.ALUSrcB   = SRCB_FOUR;
        ctrl.resultSrc = RES_ALURESULT;
        ctrl.regWrite  = 1'b1;
      end
      LUI: begin
        ctrl.resultSrc = RES_IMMEXT;
        ctrl.immSrc    = IMM_U;
        ctrl.regWrite  = 1'b1;
      end
      default: ;
    endcase
    // Reset may land mid-instruction, so the state alone cannot be trusted while rst is high.
    if (rst) begin
      ctrl.PCWrite    = 1'b0;
      ctrl.IRWrite    = 1'b0;
      ctrl.memWrite   = 1'b0;
      ctrl.regWrite   = 1'b0;
      ctrl.adrSrc     = 1'b0;
      ctrl.ALUSrcA    = SRCA_PC;
      ctrl.ALUSrcB    = SRCB_FOUR;
      ctrl.ALUControl = ALU_ADD;
      ctrl.resultSrc  = RES_ALURESULT;
      ctrl.immSrc     = IMM_I;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// tb/tb_riscv_multicycle_controller.sv - directed and random instruction traces against a per-instruction reference
module tb_riscv_multicycle_controller;

  typedef logic [16:0] cw_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  cw_t  exp_q[$];

  riscv_multicycle_controller_if bus ();

  riscv_multicycle_controller dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus.master)
  );

  always #5 clk = ~clk;

  // {PCWrite, adrSrc, memWrite, IRWrite, resultSrc, ALUControl, ALUSrcA, ALUSrcB, immSrc, regWrite}
  function automatic cw_t mk(input int pc, input int adr, input int mw, input int ir, input int rs,
                             input int alu, input int sa, input int sb, input int imm, input int rw);
    return {pc[0], adr[0], mw[0], ir[0], rs[1:0], alu[2:0], sa[1:0], sb[1:0], imm[2:0], rw[0]};
  endfunction

  function automatic cw_t observed();
    return {bus.PCWrite, bus.adrSrc, bus.memWrite, bus.IRWrite, bus.resultSrc, bus.ALUControl,
            bus.ALUSrcA, bus.ALUSrcB, bus.immSrc, bus.regWrite};
  endfunction

  function automatic int imm_of(input logic [6:0] op);
    case (op)
      7'h13, 7'h03, 7'h67: return 0;
      7'h23: return 1;
      7'h63: return 2;
      7'h6F: return 3;
      7'h37: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int alu_of(input logic [2:0] f3, input logic f7, input bit rtype);
    case (f3)
      3'd0: return (rtype && f7) ? 1 : 0;
      3'd7: return 2;
      3'd6: return 3;
      3'd4: return 4;
      3'd2: return 5;
      3'd3: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'd0: return int'(z);
      3'd1: return int'(!z);
      3'd4: return int'(n);
      3'd5: return int'(!n);
      default: return 0;
    endcase
  endfunction

  // Expected control word for every cycle of one instruction, FETCH first.
  function automatic void build(input logic [31:0] instr, input logic z, input logic n);
    logic [6:0] op;
    logic [2:0] f3;
    int im;
    op = instr[6:0];
    f3 = instr[14:12];
    im = imm_of(op);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, im, 0));
    case (op)
      7'h33: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, alu_of(f3, instr[30], 1), 2, 0, im, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, im, 1));
      end
      7'h13: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, alu_of(f3, instr[30], 0), 2, 1, im, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, im, 1));
      end
      7'h03: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, im, 0));
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, im, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, im, 1));
      end
      7'h23: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, im, 0));
        exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, im, 0));
      end
      7'h63: exp_q.push_back(mk(taken(f3, z, n), 0, 0, 0, 0, 1, 2, 0, im, 0));
      7'h6F: begin
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, im, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 2, 0, 1, 2, im, 1));
      end
      7'h67: begin
        exp_q.push_back(mk(1, 0, 0, 0, 2, 0, 2, 1, im, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 2, 0, 1, 2, im, 1));
      end
      7'h37: exp_q.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 4, 1));
      default: ;
    endcase
  endfunction

  task automatic check_cw(input string tag, input cw_t exp);
    cw_t obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  // Entered and left at the falling edge of a FETCH cycle (or of cycle lim when lim truncates).
  task automatic run_instr(input string name, input logic [31:0] instr, input logic z, input logic n,
                           input int lim);
    int total;
    build(instr, z, n);
    total = exp_q.size();
    bus.op    = instr[6:0];
    bus.func3 = instr[14:12];
    bus.func7 = instr[30];
    bus.zero  = z;
    bus.neg   = n;
    for (int i = 0; i < total && i < lim; i++) begin
      #1;
      check_cw($sformatf("%s c%0d", name, i), exp_q[i]);
      @(posedge clk);
      @(negedge clk);
    end
    if (lim >= total) begin
      #1;
      checks++;
      assert ((bus.IRWrite === 1'b1) && (bus.PCWrite === 1'b1)) else begin
        errors++;
        $error("FAIL %s cpi observed IRWrite=%b PCWrite=%b expected 1/1 after %0d cycles",
               name, bus.IRWrite, bus.PCWrite, total);
      end
    end
  endtask

  initial begin
    logic [6:0]  ops [8];
    logic [31:0] instr;
    logic [6:0]  opr;
    cw_t         rst_cw;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    rst_cw = mk(0, 0, 0, 0, 2, 0, 0, 2, 0, 0);
    bus.op = 7'h03; bus.func3 = 3'd2; bus.func7 = 1'b0; bus.zero = 1'b0; bus.neg = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_cw("reset_hold", rst_cw);
    rst = 1'b0;

    run_instr("add",  32'h002081B3, 1'b0, 1'b0, 99);
    run_instr("sub",  32'h402081B3, 1'b0, 1'b0, 99);
    run_instr("addi_f7", 32'h40008093, 1'b0, 1'b0, 99);
    run_instr("lw",   32'h0080A283, 1'b0, 1'b0, 99);
    run_instr("sw",   32'h0012A423, 1'b0, 1'b0, 99);
    run_instr("beq_t", 32'h00208463, 1'b1, 1'b0, 99);
    run_instr("beq_nt", 32'h00208463, 1'b0, 1'b0, 99);
    run_instr("bge_neg", 32'h0020D463, 1'b0, 1'b1, 99);
    run_instr("blt_neg", 32'h0020C463, 1'b0, 1'b1, 99);
    run_instr("jalr", 32'h000080E7, 1'b0, 1'b0, 99);
    run_instr("jal",  32'h008000EF, 1'b0, 1'b0, 99);
    run_instr("lui",  32'h123452B7, 1'b0, 1'b0, 99);
    run_instr("op7f", 32'h0000007F, 1'b0, 1'b0, 99);

    // Reset in the middle of a load: stop after FETCH/DECODE/MEMADR, now in MEMREAD.
    run_instr("lw_part", 32'h0080A283, 1'b0, 1'b0, 3);
    rst = 1'b1;
    #1;
    check_cw("rst_midmem", rst_cw);
    @(posedge clk); @(negedge clk); #1;
    check_cw("rst_fetch", rst_cw);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    run_instr("after_rst_add", 32'h002081B3, 1'b0, 1'b0, 99);

    for (int k = 0; k < 60; k++) begin
      instr = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        opr = 7'($urandom);
        if (opr inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37}) opr = 7'h7F;
      end else begin
        opr = ops[$urandom_range(0, 7)];
      end
      instr[6:0] = opr;
      run_instr($sformatf("rnd%0d_%02h", k, opr), instr, 1'($urandom), 1'($urandom), 99);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I datapath.
- Decodes `op`/`func3`/`func7` from the instruction register.
- Sequences fetch, decode, execute, memory and writeback by driving every datapath mux select and write enable each cycle.
- Pure Moore FSM plus a combinational ALU/branch decode; the only feedback is `zero`/`neg` from the ALU.

Parameters:
- None. All encodings are fixed in the shared package.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- op  in  7  instr[6:0]
- func3  in  3  instr[14:12]
- func7  in  1  instr[30]
- zero  in  1  ALU result == 0
- neg  in  1  ALU result[31]
- PCWrite  out  1  PC register load enable
- adrSrc  out  1  memory address select: 0=PC, 1=Result
- memWrite  out  1  memory write enable
- IRWrite  out  1  IR and OldPC load enable
- resultSrc  out  2  result select: 0=ALUOut, 1=Data, 2=ALUResult, 3=ImmExt
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
- ALUSrcA  out  2  ALU A select: 0=PC, 1=OldPC, 2=A, 3=zero
- ALUSrcB  out  2  ALU B select: 0=B, 1=ImmExt, 2=const 4, 3=zero
- immSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- regWrite  out  1  register file write enable

Behaviour:
- Reset: synchronous, active-high. `rst` high at an edge forces the state to FETCH, including mid-instruction.
- While `rst` is high, PCWrite, IRWrite, memWrite and regWrite are held at 0.
- All other outputs take their FETCH values: adrSrc=0, ALUSrcA=0, ALUSrcB=2, ALUControl=add, resultSrc=2, immSrc=000.
- Unless stated otherwise in a state: all enables are 0, all selects are 0, ALUControl=add, and immSrc is decoded from `op`.
- immSrc decode: I for 0010011/0000011/1100111, S for 0100011, B for 1100011, J for 1101111, U for 0110111.
- Supported opcodes: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111.

States (one cycle each):
- FETCH: adrSrc=0, IRWrite=1, SrcA=PC, SrcB=4, add, resultSrc=2, PCWrite=1 (PC<=PC+4). -> DECODE.
- DECODE: SrcA=OldPC, SrcB=Imm, add (ALUOut<=branch/JAL target).
  - Next state: R->EXER, I-ALU->EXEI, LW/SW->MEMADR, BR->BRANCH, JAL->JAL, JALR->JALR, LUI->LUI.
  - Any other opcode -> FETCH with no write (NOP).
- MEMADR: SrcA=A, SrcB=Imm, add. LW->MEMREAD, SW->MEMWRITE.
- MEMREAD: adrSrc=1, resultSrc=0 (MDR captures). -> MEMWB.
- MEMWB: resultSrc=1, regWrite=1. -> FETCH.
- MEMWRITE: adrSrc=1, resultSrc=0, memWrite=1. -> FETCH.
- EXER: SrcA=A, SrcB=B, ALU decode. -> ALUWB.
- EXEI: SrcA=A, SrcB=Imm, ALU decode. -> ALUWB.
- ALUWB: resultSrc=0, regWrite=1. -> FETCH.
- BRANCH: SrcA=A, SrcB=B, sub, resultSrc=0. -> FETCH.
  - PCWrite is combinational: beq=zero, bne=~zero, blt=neg, bge=~neg (signed overflow ignored, by design).
  - Other func3 values: PCWrite=0.
- JAL: resultSrc=0, PCWrite=1. -> LINK.
- JALR: SrcA=A, SrcB=Imm, add, resultSrc=2, PCWrite=1. -> LINK.
- LINK: SrcA=OldPC, SrcB=4, add, resultSrc=2, regWrite=1 (rd<=OldPC+4). -> FETCH.
- LUI: resultSrc=3, immSrc=U, regWrite=1. -> FETCH.

ALU decode (EXER/EXEI):
- func3 000: add; sub only when R-type and func7=1.
- 111 and, 110 or, 100 xor, 010 slt, 011 sltu.
- 001/101 (shifts, unsupported): add, with the destination still written.

CPI (cycles per instruction, FETCH through last state):
- LW 5
- SW, R, I, JAL, JALR 4
- BR, LUI 3
- Unknown opcode 2

Other rules:
- Exactly one state register. No output depends on the next state.
- PCWrite and regWrite are never both asserted in the same cycle except when reset masking applies.

Decomposition:
- Shared package: opcode constants, state enum (FETCH..LUI, 4-bit), ALUControl codes, immSrc codes, ALUSrcA/ALUSrcB/resultSrc select codes.
- One sub-module, `riscv_alu_decoder`: combinational; inputs isRtype, func3, func7; output ALUControl.

Test Plan:
- Reset:
  - Hold rst 2 cycles mid-MEMREAD -> state=FETCH, all four enables 0 while rst=1.
  - First cycle after release: IRWrite=1, PCWrite=1, ALUSrcB=2.
- add x3,x1,x2 (0x002081B3) -> FETCH, DECODE, EXER, ALUWB; EXER ALUControl=000; ALUWB regWrite=1, resultSrc=0.
- sub (func7=1) -> EXER ALUControl=001.
- addi with instr[30]=1 -> ALUControl stays 000.
- lw x5,8(x1) (0x0080A283): 5 cycles.
  - MEMREAD adrSrc=1, memWrite=0.
  - MEMWB resultSrc=1, regWrite=1.
- sw: MEMWRITE memWrite=1, adrSrc=1, regWrite=0.
- beq with zero=1 -> BRANCH PCWrite=1, resultSrc=0.
- beq with zero=0 -> PCWrite=0.
- bge with neg=1 -> PCWrite=0.
- blt with neg=1 -> PCWrite=1.
- jalr (0x000080E7) -> JALR PCWrite=1, resultSrc=2, ALUSrcA=2; then LINK regWrite=1, ALUSrcA=1, ALUSrcB=2.
- jal -> JAL PCWrite=1, resultSrc=0; then LINK.
- lui (0x123452B7) -> LUI resultSrc=3, immSrc=100, regWrite=1; 3-cycle CPI.
- Opcode 0x7F -> DECODE then FETCH; no memWrite or regWrite asserted.
